gene_stream_tx: RTL and testbench

Transmit side of the gene-stream interface consumed by the PE front end. The block accepts one parent genome from the NIC as a burst of genes, buffers it, and checks ascending {src1,src2} order. It then replays the genes to a PE gene queue under a valid/ready handshake, optionally closing the stream with a terminator gene. One instance feeds each of the gene1/gene2 queue inputs.

---
 rtl/neat_gene_pkg.sv | 18 +
 rtl/gene_buf.sv | 23 ++
 rtl/gene_stream_tx.sv | 140 ++++++++++++++
 tb/tb_gene_stream_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neat_gene_pkg.sv
// rtl/neat_gene_pkg.sv - gene field offsets, key constants and tx FSM encoding (TERM exists only with GENE_TX_TERM_EN)
package neat_gene_pkg;

  localparam int ATTR_SZ_DEF = 8;
  localparam int SRC1_LSB    = 5 * ATTR_SZ_DEF;
  localparam int SRC2_LSB    = 4 * ATTR_SZ_DEF;
  localparam int KEY_W       = 2 * ATTR_SZ_DEF;

  // {src1,src2} all ones marks the end of a stream and is reserved when the terminator is enabled
  localparam logic [KEY_W-1:0] TERM_KEY = '1;

`ifdef GENE_TX_TERM_EN
  typedef enum logic [1:0] {LOAD = 2'd0, SEND = 2'd1, TERM = 2'd2} tx_state_t;
`else
  typedef enum logic [1:0] {LOAD = 2'd0, SEND = 2'd1} tx_state_t;
`endif

endpackage

// File: rtl/gene_buf.sv
// rtl/gene_buf.sv - genome storage: one synchronous write port, one combinational read port, no reset on contents
module gene_buf #(
  parameter int DEPTH   = 32,
  parameter int GENE_SZ = 64,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [GENE_SZ-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [GENE_SZ-1:0] rdata
);

  logic [GENE_SZ-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gene_stream_tx.sv
// rtl/gene_stream_tx.sv - buffers one genome from the NIC, checks key order, replays it to a PE gene queue
// Optional GENE_TX_TERM_EN: closes each stream with an all-ones-key terminator gene.
module gene_stream_tx
  import neat_gene_pkg::*;
#(
  parameter int GENE_SZ = 64,
  parameter int ATTR_SZ = ATTR_SZ_DEF,
  parameter int DEPTH   = 32,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [GENE_SZ-1:0] ld_gene,
  input  logic               ld_last,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [GENE_SZ-1:0] tx_gene,
  output logic               tx_last,
  output logic               done,
  output logic [CW-1:0]      gene_cnt,
  output logic               ovf,
  output logic               order_err
);

`ifdef GENE_TX_TERM_EN
  localparam logic [GENE_SZ-1:0] TERM_GENE = GENE_SZ'(TERM_KEY) << SRC2_LSB;
`endif

  tx_state_t state, state_nx;

  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        cnt;
  logic [2*ATTR_SZ-1:0] ld_key, prev_key;
  logic                 have_prev;
  logic [GENE_SZ-1:0]   rd_data;
  logic                 ld_fire, tx_fire, last_gene, final_hs, bad_key;

  assign ld_fire   = ld_valid && ld_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign ld_key    = {ld_gene[SRC1_LSB +: ATTR_SZ], ld_gene[SRC2_LSB +: ATTR_SZ]};
  assign last_gene = ({1'b0, rd_ptr} == (cnt - CW'(1)));
  assign gene_cnt  = cnt;

`ifdef GENE_TX_TERM_EN
  assign bad_key = (have_prev && (ld_key <= prev_key)) || (&ld_key);
`else
  assign bad_key = have_prev && (ld_key <= prev_key);
`endif

  gene_buf #(
    .DEPTH  (DEPTH),
    .GENE_SZ(GENE_SZ)
  ) u_buf (
    .clk  (clk),
    .we   (ld_fire),
    .waddr(wr_ptr),
    .wdata(ld_gene),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

  always_comb begin
    state_nx = state;
    ld_ready = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_gene  = '0;
    final_hs = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = (cnt < CW'(DEPTH));
        if (ld_fire && (ld_last || (cnt == CW'(DEPTH - 1)))) state_nx = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_gene  = rd_data;
`ifdef GENE_TX_TERM_EN
        if (tx_fire && last_gene) state_nx = TERM;
`else
        tx_last = last_gene;
        if (tx_fire && last_gene) begin
          state_nx = LOAD;
          final_hs = 1'b1;
        end
`endif
      end
`ifdef GENE_TX_TERM_EN
      TERM: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_gene  = TERM_GENE;
        if (tx_fire) begin
          state_nx = LOAD;
          final_hs = 1'b1;
        end
      end
`endif
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      prev_key  <= '0;
      have_prev <= 1'b0;
      ovf       <= 1'b0;
      order_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= final_hs;
      if (final_hs) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        cnt       <= '0;
        prev_key  <= '0;
        have_prev <= 1'b0;
      end else begin
        if (ld_fire) begin
          wr_ptr    <= wr_ptr + AW'(1);
          cnt       <= cnt + CW'(1);
          prev_key  <= ld_key;
          have_prev <= 1'b1;
          if (bad_key) order_err <= 1'b1;
          // a full buffer without ld_last means the genome was cut short
          if (!ld_last && (cnt == CW'(DEPTH - 1))) ovf <= 1'b1;
        end
        if (tx_fire && (state == SEND)) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gene_stream_tx.sv
// tb/tb_gene_stream_tx.sv - randomized self-checking bench for gene_stream_tx against a genome-level reference model
module tb_gene_stream_tx;

  localparam int GENE_SZ = 64;
  localparam int DEPTH   = 32;
  localparam int CW      = 6;
  localparam logic [63:0] TERM_G = 64'h0000_FFFF_0000_0000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ld_valid = 1'b0;
  logic               ld_ready;
  logic [GENE_SZ-1:0] ld_gene = '0;
  logic               ld_last = 1'b0;
  logic               tx_valid;
  logic               tx_ready = 1'b0;
  logic [GENE_SZ-1:0] tx_gene;
  logic               tx_last;
  logic               done;
  logic [CW-1:0]      gene_cnt;
  logic               ovf;
  logic               order_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] genome[$];
  bit          m_oe  = 1'b0;
  bit          m_ovf = 1'b0;

  gene_stream_tx dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_gene  (ld_gene),
    .ld_last  (ld_last),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_gene  (tx_gene),
    .tx_last  (tx_last),
    .done     (done),
    .gene_cnt (gene_cnt),
    .ovf      (ovf),
    .order_err(order_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input logic [7:0] s1, input logic [7:0] s2);
    logic [63:0] g;
    g = {$urandom, $urandom};
    g[47:40] = s1;
    g[39:32] = s2;
    return g;
  endfunction

  function automatic logic [15:0] key_of(input logic [63:0] g);
    return g[47:32];
  endfunction

  task automatic load_phase(input bit set_last);
    int n;
    int acc;
    n   = genome.size();
    acc = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < acc; i++) begin
      if (i > 0 && key_of(genome[i]) <= key_of(genome[i-1])) m_oe = 1'b1;
`ifdef GENE_TX_TERM_EN
      if (key_of(genome[i]) == 16'hFFFF) m_oe = 1'b1;
`endif
    end
    if (n > DEPTH || (n == DEPTH && !set_last)) m_ovf = 1'b1;
    for (int i = 0; i < acc; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
        ld_gene  = {$urandom, $urandom};
        step();
      end
      ld_valid = 1'b1;
      ld_gene  = genome[i];
      ld_last  = set_last && (i == n - 1);
      n_checks++;
      if (ld_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ready beat %0d: got %b expected 1", i, ld_ready);
      end
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      n_checks++;
      if (gene_cnt !== CW'(i + 1)) begin
        n_fail++;
        $display("FAIL gene_cnt beat %0d: got %0d expected %0d", i, gene_cnt, i + 1);
      end
    end
    ld_gene = '0;
    n_checks++;
    if (ld_ready !== 1'b0 || ovf !== m_ovf || order_err !== m_oe) begin
      n_fail++;
      $display("FAIL post_load: ld_ready=%b ovf=%b order_err=%b expected 0 %b %b",
               ld_ready, ovf, order_err, m_ovf, m_oe);
    end
  endtask

  task automatic tx_phase(input int mode);
    logic [63:0] exp[$];
    int acc;
    int idx;
    int cyc;
    bit rdy;
    acc = (genome.size() > DEPTH) ? DEPTH : genome.size();
    for (int i = 0; i < acc; i++) exp.push_back(genome[i]);
`ifdef GENE_TX_TERM_EN
    exp.push_back(TERM_G);
`endif
    idx = 0;
    cyc = 0;
    while (idx < exp.size() && cyc < 4000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tx_ready = rdy;
      n_checks++;
      if (tx_valid !== 1'b1 || tx_gene !== exp[idx] || tx_last !== 1'(idx == exp.size() - 1)) begin
        n_fail++;
        $display("FAIL tx_beat %0d cyc %0d: got v=%b g=%h l=%b expected v=1 g=%h l=%b",
                 idx, cyc, tx_valid, tx_gene, tx_last, exp[idx], (idx == exp.size() - 1));
      end
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL early_done cyc %0d: got %b expected 0", cyc, done);
      end
      if (rdy) idx++;
      step();
      cyc++;
    end
    tx_ready = 1'b0;
    n_checks++;
    if (idx < exp.size()) begin
      n_fail++;
      $display("FAIL tx_timeout: got %0d beats expected %0d", idx, exp.size());
    end
    n_checks++;
    if (done !== 1'b1 || ld_ready !== 1'b1 || tx_valid !== 1'b0 || gene_cnt !== '0) begin
      n_fail++;
      $display("FAIL end_of_stream: done=%b ld_ready=%b tx_valid=%b cnt=%0d expected 1 1 0 0",
               done, ld_ready, tx_valid, gene_cnt);
    end
    step();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width: got %b expected 0", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    n_checks++;
    if (ld_ready !== 1'b1 || tx_valid !== 1'b0 || tx_last !== 1'b0 || done !== 1'b0 ||
        gene_cnt !== '0 || ovf !== 1'b0 || order_err !== 1'b0 || tx_gene !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b v=%b l=%b d=%b cnt=%0d ovf=%b oe=%b g=%h",
               ld_ready, tx_valid, tx_last, done, gene_cnt, ovf, order_err, tx_gene);
    end
  endtask

  task automatic test_basic();
    genome = {mk(8'd1, 8'd2), mk(8'd1, 8'd5), mk(8'd3, 8'd0)};
    load_phase(1'b1);
    tx_phase(0);
  endtask

  task automatic test_stall();
    genome = {mk(8'd1, 8'd2), mk(8'd1, 8'd5), mk(8'd3, 8'd0)};
    load_phase(1'b1);
    tx_phase(1);
  endtask

  task automatic test_order();
    genome = {mk(8'd2, 8'd0), mk(8'd1, 8'd7)};
    load_phase(1'b1);
    n_checks++;
    if (order_err !== 1'b1) begin
      n_fail++;
      $display("FAIL order_err_set: got %b expected 1", order_err);
    end
    tx_phase(0);
    genome = {mk(8'd0, 8'd1), mk(8'd0, 8'd2), mk(8'd0, 8'd3)};
    load_phase(1'b1);
    n_checks++;
    if (order_err !== 1'b1) begin
      n_fail++;
      $display("FAIL order_err_sticky: got %b expected 1", order_err);
    end
    tx_phase(2);
  endtask

  task automatic test_overflow();
    genome.delete();
    for (int i = 0; i < DEPTH; i++) genome.push_back(mk(8'd0, 8'(i + 1)));
    load_phase(1'b0);
    ld_valid = 1'b1;
    ld_gene  = mk(8'd9, 8'd9);
    repeat (2) step();
    ld_valid = 1'b0;
    n_checks++;
    if (gene_cnt !== CW'(DEPTH) || ovf !== 1'b1 || tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_hold: cnt=%0d ovf=%b tx_valid=%b expected 32 1 1", gene_cnt, ovf, tx_valid);
    end
    tx_phase(0);
  endtask

  task automatic test_rst_mid_send();
    genome = {mk(8'd4, 8'd1), mk(8'd4, 8'd2), mk(8'd4, 8'd3), mk(8'd4, 8'd4), mk(8'd4, 8'd5)};
    load_phase(1'b1);
    for (int i = 0; i < 2; i++) begin
      tx_ready = 1'b1;
      n_checks++;
      if (tx_valid !== 1'b1 || tx_gene !== genome[i]) begin
        n_fail++;
        $display("FAIL pre_rst_beat %0d: got v=%b g=%h expected 1 %h", i, tx_valid, tx_gene, genome[i]);
      end
      step();
    end
    tx_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_oe  = 1'b0;
    m_ovf = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0 || gene_cnt !== '0 || ld_ready !== 1'b1 || ovf !== 1'b0 ||
        order_err !== 1'b0 || done !== 1'b0 || tx_gene !== '0) begin
      n_fail++;
      $display("FAIL mid_send_rst: v=%b cnt=%0d rdy=%b ovf=%b oe=%b d=%b g=%h",
               tx_valid, gene_cnt, ld_ready, ovf, order_err, done, tx_gene);
    end
    genome = {mk(8'd7, 8'd7)};
    load_phase(1'b1);
    tx_phase(0);
  endtask

  task automatic test_single();
    genome = {mk(8'hFF, 8'hFF)};
    load_phase(1'b1);
    tx_phase(2);
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 6; k++) begin
      genome.delete();
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        genome.push_back(mk(8'($urandom_range(0, 3) == 0 ? 255 : $urandom_range(0, 3)),
                            8'($urandom_range(0, 255))));
      load_phase(1'b1);
      tx_phase(2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_order();
    test_overflow();
    test_rst_mid_send();
    test_single();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
